// File: rtl/mm_bst_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the burst arbiter.
// Field widths are sized for the largest supported configuration.
package mm_bst_arbiter_pkg;

   localparam int MAX_PORTS = 32;
   localparam int PORT_W    = 5;
   localparam int LEN_W     = 16;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      WLOCK = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic [PORT_W-1:0] port;
      logic [LEN_W-1:0]  len;
   } route_entry_t;

   typedef struct packed {
      logic              found;
      logic [PORT_W-1:0] idx;
   } rr_pick_t;

   // First candidate at or after ptr, wrapping at nports; idx falls back to ptr.
   function automatic rr_pick_t rr_pick(input logic [MAX_PORTS-1:0] cand,
                                        input logic [PORT_W-1:0] ptr,
                                        input int nports);
      rr_pick_t res;
      int       idx;
      res.found = 1'b0;
      res.idx   = ptr;
      for (int i = 0; i < MAX_PORTS; i++) begin
         idx = int'(ptr) + i;
         if (idx >= nports) begin
            idx = idx - nports;
         end
         if ((i < nports) && !res.found && cand[idx[PORT_W-1:0]]) begin
            res.found = 1'b1;
            res.idx   = idx[PORT_W-1:0];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/mm_bst_route_fifo.sv
// In-order queue of outstanding read bursts {port, len}.
// Full/empty are registered, so a pop never frees a slot in the same cycle.
module mm_bst_route_fifo
   import mm_bst_arbiter_pkg::*;
#(
   parameter int RDEPTH = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  route_entry_t din,
   input  logic         pop,
   output route_entry_t dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;

   route_entry_t  mem [RDEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic [AW:0]   cnt_nxt;
   logic          do_push;
   logic          do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_comb begin
      cnt_nxt = cnt;
      if (do_push && !do_pop) begin
         cnt_nxt = cnt + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
         cnt_nxt = cnt - (AW+1)'(1);
      end else begin
         cnt_nxt = cnt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         cnt   <= cnt_nxt;
         full  <= (cnt_nxt == (AW+1)'(RDEPTH));
         empty <= (cnt_nxt == (AW+1)'(0));
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/mm_bst_arbiter.sv
// Round-robin arbiter sharing one burst MM slave among NPORTS masters.
// Write bursts are locked to one port; read returns are routed in order.
module mm_bst_arbiter
   import mm_bst_arbiter_pkg::*;
#(
   parameter int NPORTS = 2,
   parameter int DWIDTH = 16,
   parameter int AWIDTH = 8,
   parameter int BWIDTH = 4,
   parameter int RDEPTH = 8
) (
   input  logic                     reset,
   input  logic                     clk,
   input  logic [NPORTS*AWIDTH-1:0] s_addr,
   input  logic [NPORTS*BWIDTH-1:0] s_bcnt,
   input  logic [NPORTS-1:0]        s_wreq,
   input  logic [NPORTS*DWIDTH-1:0] s_wdat,
   input  logic [NPORTS-1:0]        s_rreq,
   output logic [NPORTS*DWIDTH-1:0] s_rdat,
   output logic [NPORTS-1:0]        s_rval,
   output logic [NPORTS-1:0]        s_busy,
   output logic [AWIDTH-1:0]        m_addr,
   output logic [BWIDTH-1:0]        m_bcnt,
   output logic                     m_wreq,
   output logic [DWIDTH-1:0]        m_wdat,
   output logic                     m_rreq,
   input  logic [DWIDTH-1:0]        m_rdat,
   input  logic                     m_rval,
   input  logic                     m_busy
);

   arb_state_t        state;
   arb_state_t        state_nxt;
   logic [PORT_W-1:0] ptr;
   logic [PORT_W-1:0] ptr_nxt;
   logic [PORT_W-1:0] gnt;
   logic [PORT_W-1:0] gnt_nxt;
   logic [PORT_W-1:0] sel;
   logic [BWIDTH-1:0] wcnt;
   logic [BWIDTH-1:0] wcnt_nxt;
   logic [BWIDTH-1:0] rcnt;
   logic [BWIDTH-1:0] rcnt_nxt;
   logic [MAX_PORTS-1:0] cand;
   rr_pick_t          pick;
   logic              hit;
   logic              wreq_sel;
   logic              rreq_sel;
   logic              wr_acc;
   logic              rd_acc;
   logic              rd_last;
   logic              q_full;
   logic              q_empty;
   logic              q_pop;
   route_entry_t      q_head;

   function automatic logic [PORT_W-1:0] next_port(input logic [PORT_W-1:0] p);
      return (p == PORT_W'(NPORTS-1)) ? PORT_W'(0) : p + PORT_W'(1);
   endfunction

   // A read only competes while the route queue has room.
   always_comb begin
      cand = '0;
      for (int p = 0; p < NPORTS; p++) begin
         cand[p] = s_wreq[p] | (s_rreq[p] & ~q_full);
      end
      pick = rr_pick(cand, ptr, NPORTS);
   end

   assign sel = (state == WLOCK) ? gnt : pick.idx;

   always_comb begin
      m_addr   = '0;
      m_bcnt   = '0;
      m_wdat   = '0;
      wreq_sel = 1'b0;
      rreq_sel = 1'b0;
      hit      = 1'b0;
      for (int p = 0; p < NPORTS; p++) begin
         hit      = (PORT_W'(p) == sel);
         m_addr   = m_addr | (s_addr[p*AWIDTH +: AWIDTH] & {AWIDTH{hit}});
         m_bcnt   = m_bcnt | (s_bcnt[p*BWIDTH +: BWIDTH] & {BWIDTH{hit}});
         m_wdat   = m_wdat | (s_wdat[p*DWIDTH +: DWIDTH] & {DWIDTH{hit}});
         wreq_sel = wreq_sel | (s_wreq[p] & hit);
         rreq_sel = rreq_sel | (s_rreq[p] & hit);
      end
   end

   assign m_wreq = wreq_sel;
   assign m_rreq = (state == IDLE) & pick.found & rreq_sel & ~q_full;
   assign wr_acc = m_wreq & ~m_busy;
   assign rd_acc = m_rreq & ~m_busy;

   // The selected port sees the slave stall; a read held off by a full queue also stalls.
   always_comb begin
      for (int p = 0; p < NPORTS; p++) begin
         s_busy[p] = (PORT_W'(p) == sel)
                   ? (m_busy | ((state == IDLE) & rreq_sel & q_full))
                   : 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      gnt_nxt   = gnt;
      wcnt_nxt  = wcnt;
      case (state)
         IDLE: begin
            if (rd_acc) begin
               ptr_nxt = next_port(sel);
            end else if (wr_acc) begin
               wcnt_nxt = m_bcnt - BWIDTH'(1);
               if (m_bcnt == BWIDTH'(1)) begin
                  ptr_nxt = next_port(sel);
               end else begin
                  state_nxt = WLOCK;
                  gnt_nxt   = sel;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         WLOCK: begin
            if (wr_acc) begin
               wcnt_nxt = wcnt - BWIDTH'(1);
               if (wcnt == BWIDTH'(1)) begin
                  ptr_nxt   = next_port(gnt);
                  state_nxt = IDLE;
               end else begin
                  state_nxt = WLOCK;
               end
            end else begin
               state_nxt = WLOCK;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Returned words go to the head entry's port; data with nothing queued is dropped.
   always_comb begin
      rd_last  = ((LEN_W'(rcnt) + LEN_W'(1)) == q_head.len);
      q_pop    = m_rval & ~q_empty & rd_last;
      rcnt_nxt = rcnt;
      if (m_rval && !q_empty) begin
         rcnt_nxt = rd_last ? BWIDTH'(0) : rcnt + BWIDTH'(1);
      end else begin
         rcnt_nxt = rcnt;
      end
      for (int p = 0; p < NPORTS; p++) begin
         s_rval[p] = m_rval & ~q_empty & (q_head.port == PORT_W'(p));
      end
   end

   assign s_rdat = {NPORTS{m_rdat}};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         ptr   <= '0;
         gnt   <= '0;
         wcnt  <= '0;
         rcnt  <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         gnt   <= gnt_nxt;
         wcnt  <= wcnt_nxt;
         rcnt  <= rcnt_nxt;
      end
   end

   mm_bst_route_fifo #(
      .RDEPTH (RDEPTH)
   ) u_route_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (rd_acc),
      .din   ({sel, LEN_W'(m_bcnt)}),
      .pop   (q_pop),
      .dout  (q_head),
      .full  (q_full),
      .empty (q_empty)
   );

endmodule

// File: tb/tb_mm_bst_arbiter.sv
// Directed bench for mm_bst_arbiter (2 ports, 2-deep route queue).
// Inputs change just after the falling edge; outputs are checked 1 time unit later.
module tb_mm_bst_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] s_addr;
   logic [7:0]  s_bcnt;
   logic [1:0]  s_wreq;
   logic [31:0] s_wdat;
   logic [1:0]  s_rreq;
   logic [31:0] s_rdat;
   logic [1:0]  s_rval;
   logic [1:0]  s_busy;
   logic [7:0]  m_addr;
   logic [3:0]  m_bcnt;
   logic        m_wreq;
   logic [15:0] m_wdat;
   logic        m_rreq;
   logic [15:0] m_rdat;
   logic        m_rval;
   logic        m_busy;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mm_bst_arbiter #(
      .NPORTS (2), .DWIDTH (16), .AWIDTH (8), .BWIDTH (4), .RDEPTH (2)
   ) dut (
      .reset  (reset),  .clk    (clk),
      .s_addr (s_addr), .s_bcnt (s_bcnt), .s_wreq (s_wreq), .s_wdat (s_wdat),
      .s_rreq (s_rreq), .s_rdat (s_rdat), .s_rval (s_rval), .s_busy (s_busy),
      .m_addr (m_addr), .m_bcnt (m_bcnt), .m_wreq (m_wreq), .m_wdat (m_wdat),
      .m_rreq (m_rreq), .m_rdat (m_rdat), .m_rval (m_rval), .m_busy (m_busy)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_port(input int p, input logic [7:0] a, input logic [3:0] b,
                           input logic [15:0] d);
      s_addr[p*8 +: 8]  = a;
      s_bcnt[p*4 +: 4]  = b;
      s_wdat[p*16 +: 16] = d;
   endtask

   task automatic quiet();
      s_wreq = 2'b00;
      s_rreq = 2'b00;
      m_rval = 1'b0;
      m_busy = 1'b0;
      m_rdat = 16'h0000;
   endtask

   task automatic do_reset();
      quiet();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      int wc[2];
      int g;
      int w;
      int acc_exp;
      int acc_obs;
      s_addr = 16'h0000;
      s_bcnt = 8'h00;
      s_wdat = 32'h0;
      quiet();
      reset = 1'b1;
      #1;
      check_val("rst_m_wreq", 32'(m_wreq), 32'd0);
      check_val("rst_m_rreq", 32'(m_rreq), 32'd0);
      check_val("rst_s_rval", 32'(s_rval), 32'd0);
      check_val("rst_s_busy", 32'(s_busy), 32'h2);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // single port write burst of 4
      set_port(0, 8'h10, 4'd4, 16'h0000);
      for (int k = 0; k < 4; k++) begin
         s_wreq = 2'b01;
         s_wdat[15:0] = 16'(32'h1000 + k);
         #1;
         check_val("t1_wreq", 32'(m_wreq), 32'd1);
         check_val("t1_wdat", 32'(m_wdat), 32'h1000 + k);
         check_val("t1_addr", 32'(m_addr), 32'h10);
         check_val("t1_bcnt", 32'(m_bcnt), 32'd4);
         check_val("t1_busy", 32'(s_busy), 32'h2);
         @(negedge clk);
      end
      s_wreq = 2'b00;
      #1;
      check_val("t1_done_wreq", 32'(m_wreq), 32'd0);
      check_val("t1_done_busy", 32'(s_busy), 32'h1);
      @(negedge clk);

      // two ports writing bursts of 3 back to back
      do_reset();
      set_port(0, 8'h40, 4'd3, 16'h0000);
      set_port(1, 8'h50, 4'd3, 16'h0000);
      wc[0] = 0;
      wc[1] = 0;
      for (int c = 0; c < 12; c++) begin
         g = (c / 3) % 2;
         s_wreq = 2'b11;
         s_wdat[15:0]  = 16'(32'hA000 + wc[0]);
         s_wdat[31:16] = 16'(32'hA100 + wc[1]);
         #1;
         check_val("t2_busy", 32'(s_busy), (g == 0) ? 32'h2 : 32'h1);
         check_val("t2_wdat", 32'(m_wdat), 32'hA000 + 32'(g) * 32'h100 + 32'(wc[g]));
         check_val("t2_addr", 32'(m_addr), (g == 0) ? 32'h40 : 32'h50);
         wc[g] = wc[g] + 1;
         @(negedge clk);
      end
      s_wreq = 2'b00;

      // reads from both ports, data routed back in order
      do_reset();
      set_port(0, 8'h20, 4'd2, 16'h0000);
      set_port(1, 8'h30, 4'd3, 16'h0000);
      s_rreq = 2'b11;
      #1;
      check_val("t3_rreq0", 32'(m_rreq), 32'd1);
      check_val("t3_addr0", 32'(m_addr), 32'h20);
      check_val("t3_bcnt0", 32'(m_bcnt), 32'd2);
      check_val("t3_busy0", 32'(s_busy), 32'h2);
      check_val("t3_wreq0", 32'(m_wreq), 32'd0);
      @(negedge clk);
      s_rreq = 2'b10;
      #1;
      check_val("t3_rreq1", 32'(m_rreq), 32'd1);
      check_val("t3_addr1", 32'(m_addr), 32'h30);
      check_val("t3_bcnt1", 32'(m_bcnt), 32'd3);
      check_val("t3_busy1", 32'(s_busy), 32'h1);
      @(negedge clk);
      s_rreq = 2'b00;
      for (int i = 0; i < 5; i++) begin
         m_rval = 1'b1;
         m_rdat = 16'(32'hB000 + i);
         #1;
         check_val("t3_rval", 32'(s_rval), (i < 2) ? 32'h1 : 32'h2);
         check_val("t3_rdat", s_rdat, {2{16'(32'hB000 + i)}});
         @(negedge clk);
      end
      m_rval = 1'b1;
      m_rdat = 16'hBEEF;
      #1;
      check_val("t3_orphan", 32'(s_rval), 32'd0);
      @(negedge clk);
      m_rval = 1'b0;
      #1;
      check_val("t3_quiet", 32'(s_rval), 32'd0);
      @(negedge clk);

      // full route queue holds the third read until the first burst returns
      do_reset();
      set_port(0, 8'h60, 4'd2, 16'h0000);
      s_rreq = 2'b01;
      #1;
      check_val("t4_rd1_rreq", 32'(m_rreq), 32'd1);
      check_val("t4_rd1_busy", 32'(s_busy), 32'h2);
      @(negedge clk);
      #1;
      check_val("t4_rd2_rreq", 32'(m_rreq), 32'd1);
      check_val("t4_rd2_busy", 32'(s_busy), 32'h2);
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
         #1;
         check_val("t4_full_rreq", 32'(m_rreq), 32'd0);
         check_val("t4_full_busy", 32'(s_busy), 32'h1);
         @(negedge clk);
      end
      for (int i = 0; i < 2; i++) begin
         m_rval = 1'b1;
         m_rdat = 16'(32'hB100 + i);
         #1;
         check_val("t4_ret_rval", 32'(s_rval), 32'h1);
         check_val("t4_ret_busy", 32'(s_busy), 32'h1);
         check_val("t4_ret_rreq", 32'(m_rreq), 32'd0);
         @(negedge clk);
      end
      m_rval = 1'b0;
      #1;
      check_val("t4_rd3_rreq", 32'(m_rreq), 32'd1);
      check_val("t4_rd3_busy", 32'(s_busy), 32'h2);
      @(negedge clk);
      s_rreq = 2'b00;

      // slave stalls every other cycle during a burst of 5
      do_reset();
      set_port(0, 8'h70, 4'd5, 16'h0000);
      set_port(1, 8'h71, 4'd2, 16'hD000);
      s_wreq = 2'b11;
      w = 0;
      acc_exp = 0;
      acc_obs = 0;
      for (int c = 0; c < 20 && acc_exp < 5; c++) begin
         m_busy = (c % 2 == 0);
         s_wdat[15:0] = 16'(32'hC000 + w);
         #1;
         check_val("t5_busy", 32'(s_busy), {30'd0, 1'b1, m_busy});
         check_val("t5_wdat", 32'(m_wdat), 32'hC000 + 32'(w));
         check_val("t5_wreq", 32'(m_wreq), 32'd1);
         if (m_wreq && !m_busy) begin
            acc_obs++;
         end
         if (!m_busy) begin
            w++;
            acc_exp++;
         end
         @(negedge clk);
      end
      check_val("t5_words", 32'(acc_obs), 32'd5);
      m_busy = 1'b0;
      #1;
      check_val("t5_next_busy", 32'(s_busy), 32'h1);
      check_val("t5_next_wdat", 32'(m_wdat), 32'hD000);
      @(negedge clk);
      s_wreq = 2'b00;

      // reset in the middle of a locked burst from port 1
      do_reset();
      set_port(0, 8'h80, 4'd1, 16'hE000);
      s_wreq = 2'b01;
      #1;
      check_val("t6_single_busy", 32'(s_busy), 32'h2);
      @(negedge clk);
      set_port(1, 8'h90, 4'd4, 16'hE100);
      s_wreq = 2'b10;
      for (int k = 0; k < 2; k++) begin
         s_wdat[31:16] = 16'(32'hE100 + k);
         #1;
         check_val("t6_burst_busy", 32'(s_busy), 32'h1);
         check_val("t6_burst_wdat", 32'(m_wdat), 32'hE100 + k);
         @(negedge clk);
      end
      s_wreq = 2'b11;
      #1;
      check_val("t6_lock_busy", 32'(s_busy), 32'h1);
      s_wreq = 2'b00;
      reset = 1'b1;
      #1;
      check_val("t6_rst_wreq", 32'(m_wreq), 32'd0);
      check_val("t6_rst_rreq", 32'(m_rreq), 32'd0);
      check_val("t6_rst_rval", 32'(s_rval), 32'd0);
      check_val("t6_rst_busy", 32'(s_busy), 32'h2);
      @(negedge clk);
      reset = 1'b0;
      s_wreq = 2'b11;
      #1;
      check_val("t6_first_busy", 32'(s_busy), 32'h2);
      check_val("t6_first_addr", 32'(m_addr), 32'h80);
      @(negedge clk);
      s_wreq = 2'b00;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
